// File: rtl/qbus_pkg.sv
// Shared QBUS slave definitions: bus FSM encoding, register offsets and bit positions.
package qbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_IAK   = 3'd5
  } bus_state_t;

  // Register index is the word offset within the 8-byte window (byte address bits 2:1).
  localparam logic [1:0] REG_RCSR = 2'd0;
  localparam logic [1:0] REG_RBUF = 2'd1;
  localparam logic [1:0] REG_XCSR = 2'd2;
  localparam logic [1:0] REG_XBUF = 2'd3;

  localparam int CSR_DONE = 7;
  localparam int CSR_RDY  = 7;
  localparam int CSR_IE   = 6;
  localparam int RBUF_ERR = 15;
  localparam int RBUF_OVR = 14;

  function automatic logic addr_hit(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:3] == base[15:3];
  endfunction

endpackage

// File: rtl/qbus_dl11_if.sv
// QBUS pin bundle for the DL11 slave; all strobes and data lines are active-low.
interface qbus_dl11_if;
  logic [15:0] pin_ad_n;
  logic [15:0] ad_out_n;
  logic        ad_oe;
  logic        pin_sync_n;
  logic        pin_din_n;
  logic        pin_dout_n;
  logic        pin_wtbt_n;
  logic        pin_iako_n;
  logic        pin_rply_n;
  logic        pin_virq_n;
  logic        iako_out_n;

  modport slave (
    input  pin_ad_n, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_iako_n,
    output ad_out_n, ad_oe, pin_rply_n, pin_virq_n, iako_out_n
  );

  modport master (
    output pin_ad_n, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_iako_n,
    input  ad_out_n, ad_oe, pin_rply_n, pin_virq_n, iako_out_n
  );
endinterface

// File: rtl/qbus_sync.sv
// Two-flop synchroniser for one asynchronous active-low QBUS strobe; idles high.
module qbus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/qbus_dl11.sv
// DL11-style serial line interface as a QBUS slave: four registers, two interrupt
// vectors, and a byte-wide receive/transmit side.
module qbus_dl11
  import qbus_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'o177560,
  parameter logic [15:0] VECTOR   = 16'o000060,
  parameter int          RPLY_DLY = 2
) (
  input  logic              pin_clk,
  input  logic              pin_init_n,
  qbus_dl11_if.slave        bus,
  // rx_stb/tx_stb/tx_ack are single-cycle strobes: the data beside a strobe is
  // valid only in that cycle, and no stall or back-pressure exists on either side.
  input  logic [7:0]        rx_data,
  input  logic              rx_stb,
  output logic [7:0]        tx_data,
  output logic              tx_stb,
  input  logic              tx_ack,
  output bus_state_t        state_dbg
);

  logic sync_n_s, din_n_s, dout_n_s, wtbt_n_s, iako_n_s;

  qbus_sync u_sync_sync (.clk(pin_clk), .rst_n(pin_init_n), .d(bus.pin_sync_n), .q(sync_n_s));
  qbus_sync u_sync_din  (.clk(pin_clk), .rst_n(pin_init_n), .d(bus.pin_din_n),  .q(din_n_s));
  qbus_sync u_sync_dout (.clk(pin_clk), .rst_n(pin_init_n), .d(bus.pin_dout_n), .q(dout_n_s));
  qbus_sync u_sync_wtbt (.clk(pin_clk), .rst_n(pin_init_n), .d(bus.pin_wtbt_n), .q(wtbt_n_s));
  qbus_sync u_sync_iako (.clk(pin_clk), .rst_n(pin_init_n), .d(bus.pin_iako_n), .q(iako_n_s));

  logic sync_a, din_a, dout_a, wtbt_a, iako_a;
  assign sync_a = ~sync_n_s;
  assign din_a  = ~din_n_s;
  assign dout_a = ~dout_n_s;
  assign wtbt_a = ~wtbt_n_s;
  assign iako_a = ~iako_n_s;

  bus_state_t  state;
  logic        sync_a_q;
  logic [1:0]  reg_sel;
  logic        addr_odd;
  logic        iak_hit;
  logic [3:0]  cnt;
  logic        rply_n_q, oe_q, iako_out_n_q;
  logic [15:0] ad_out_n_q;

  logic        done, err, ovr, rie, xie, rdy;
  logic [7:0]  rbuf_data;
  logic        rx_req, tx_req, rx_cond_q, tx_cond_q;

  logic [15:0] bus_addr;
  logic [7:0]  wdata;
  logic        sync_fall, go_addr, go_iak, go_read, go_write, rd_end, rbuf_clr;
  logic        deliver_rx, deliver_tx, wr_low, rx_cond, tx_cond;
  logic [15:0] rdata;

  assign bus_addr  = ~bus.pin_ad_n;
  assign wdata     = ~bus.pin_ad_n[7:0];
  assign sync_fall = sync_a && !sync_a_q;

  // Transaction events, shared by the FSM and the register bank so that side
  // effects land on the same edge as the state change that causes them.
  assign go_addr    = (state == ST_IDLE) && sync_fall && addr_hit(bus_addr, BASE);
  assign go_iak     = (state == ST_IDLE) && !sync_a && din_a && iako_a;
  assign go_read    = (state == ST_ADDR) && sync_a && din_a;
  assign go_write   = (state == ST_ADDR) && sync_a && !din_a && dout_a;
  assign rd_end     = (state == ST_READ) && sync_a && (cnt == 4'd0);
  assign rbuf_clr   = rd_end && (reg_sel == REG_RBUF);
  assign deliver_rx = go_iak && rx_req;
  assign deliver_tx = go_iak && !rx_req && tx_req;
  // Odd-byte writes target bits 15:8, where nothing is writable.
  assign wr_low     = !(wtbt_a && addr_odd);
  assign rx_cond    = done && rie;
  assign tx_cond    = rdy && xie;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_RCSR: begin
        rdata[CSR_DONE] = done;
        rdata[CSR_IE]   = rie;
      end
      REG_RBUF: begin
        rdata[RBUF_ERR] = err;
        rdata[RBUF_OVR] = ovr;
        rdata[7:0]      = rbuf_data;
      end
      REG_XCSR: begin
        rdata[CSR_RDY] = rdy;
        rdata[CSR_IE]  = xie;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      state        <= ST_IDLE;
      sync_a_q     <= 1'b0;
      reg_sel      <= REG_RCSR;
      addr_odd     <= 1'b0;
      iak_hit      <= 1'b0;
      cnt          <= 4'd0;
      rply_n_q     <= 1'b1;
      oe_q         <= 1'b0;
      ad_out_n_q   <= 16'hFFFF;
      iako_out_n_q <= 1'b1;
    end else begin
      sync_a_q <= sync_a;
      case (state)
        ST_IDLE: begin
          if (go_addr) begin
            state    <= ST_ADDR;
            reg_sel  <= bus_addr[2:1];
            addr_odd <= bus_addr[0];
          end else if (go_iak) begin
            state <= ST_IAK;
            cnt   <= 4'(RPLY_DLY - 1);
            if (rx_req || tx_req) begin
              iak_hit    <= 1'b1;
              oe_q       <= 1'b1;
              ad_out_n_q <= rx_req ? ~VECTOR : ~(VECTOR + 16'd4);
            end else begin
              iak_hit      <= 1'b0;
              iako_out_n_q <= 1'b0;
            end
          end
        end
        ST_ADDR: begin
          if (!sync_a) begin
            state <= ST_IDLE;
          end else if (din_a) begin
            state      <= ST_READ;
            oe_q       <= 1'b1;
            ad_out_n_q <= ~rdata;
            cnt        <= 4'(RPLY_DLY - 1);
          end else if (dout_a) begin
            state <= ST_WRITE;
            cnt   <= 4'(RPLY_DLY - 1);
          end
        end
        ST_READ, ST_WRITE: begin
          if (!sync_a) begin
            state      <= ST_IDLE;
            rply_n_q   <= 1'b1;
            oe_q       <= 1'b0;
            ad_out_n_q <= 16'hFFFF;
          end else if (cnt == 4'd0) begin
            state    <= ST_HOLD;
            rply_n_q <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (!sync_a) begin
            state      <= ST_IDLE;
            rply_n_q   <= 1'b1;
            oe_q       <= 1'b0;
            ad_out_n_q <= 16'hFFFF;
          end else if (!din_a && !dout_a) begin
            state      <= ST_ADDR;
            rply_n_q   <= 1'b1;
            oe_q       <= 1'b0;
            ad_out_n_q <= 16'hFFFF;
          end
        end
        ST_IAK: begin
          if (!din_a) begin
            state        <= ST_IDLE;
            rply_n_q     <= 1'b1;
            oe_q         <= 1'b0;
            ad_out_n_q   <= 16'hFFFF;
            iako_out_n_q <= 1'b1;
          end else if (iak_hit) begin
            if (cnt == 4'd0) rply_n_q <= 1'b0;
            else             cnt      <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pin_clk or negedge pin_init_n) begin
    if (!pin_init_n) begin
      done      <= 1'b0;
      err       <= 1'b0;
      ovr       <= 1'b0;
      rie       <= 1'b0;
      xie       <= 1'b0;
      rdy       <= 1'b1;
      rbuf_data <= 8'd0;
      tx_data   <= 8'd0;
      tx_stb    <= 1'b0;
      rx_req    <= 1'b0;
      tx_req    <= 1'b0;
      rx_cond_q <= 1'b0;
      tx_cond_q <= 1'b0;
    end else begin
      tx_stb <= 1'b0;
      if (rbuf_clr) begin
        done <= 1'b0;
        err  <= 1'b0;
        ovr  <= 1'b0;
      end
      // A byte arriving on the same edge as the RBUF read clear wins, without overrun.
      if (rx_stb) begin
        rbuf_data <= rx_data;
        done      <= 1'b1;
        if (done && !rbuf_clr) begin
          ovr <= 1'b1;
          err <= 1'b1;
        end
      end
      if (tx_ack) rdy <= 1'b1;
      if (go_write && wr_low) begin
        case (reg_sel)
          REG_RCSR: rie <= wdata[CSR_IE];
          REG_XCSR: xie <= wdata[CSR_IE];
          REG_XBUF: begin
            tx_data <= wdata;
            rdy     <= 1'b0;
            tx_stb  <= 1'b1;
          end
          default: ;
        endcase
      end
      rx_cond_q <= rx_cond;
      tx_cond_q <= tx_cond;
      if (!rx_cond)                   rx_req <= 1'b0;
      else if (!rx_cond_q)            rx_req <= 1'b1;
      else if (deliver_rx)            rx_req <= 1'b0;
      if (!tx_cond)                   tx_req <= 1'b0;
      else if (!tx_cond_q)            tx_req <= 1'b1;
      else if (deliver_tx)            tx_req <= 1'b0;
    end
  end

  assign bus.ad_out_n   = ad_out_n_q;
  assign bus.ad_oe      = oe_q;
  assign bus.pin_rply_n = rply_n_q;
  assign bus.pin_virq_n = ~(rx_req | tx_req);
  assign bus.iako_out_n = iako_out_n_q;
  assign state_dbg      = state;

endmodule
